// File: rtl/blob_unpacker.sv
// blob_unpacker: drains 32-bit words from an output-buffer FIFO and emits
// them as a stream of FP16 halfwords, low half first, with a last flag on
// the final halfword and a one-cycle done pulse at the end of each transfer.
module blob_unpacker (
    input  logic        clk,
    input  logic        reset_d,
    // request side
    input  logic        req_valid,
    input  logic [15:0] req_len,
    output logic        req_ready,
    // output-buffer FIFO side
    input  logic        ob_empty,
    output logic        ob_re,
    input  logic [31:0] ob_data,
    input  logic        ob_valid,
    // halfword stream
    output logic        px_valid,
    output logic [15:0] px_data,
    output logic        px_last,
    input  logic        px_ready,
    // status
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EMIT_LO = 3'd3,
        ST_EMIT_HI = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] count_reg;   // words still to be emitted, including the current one
    logic [15:0] count_next;
    logic [31:0] hold_reg;    // word currently being split into halfwords
    logic [31:0] hold_next;

    // State, word counter and hold register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset_d) begin
        if (reset_d) begin
            state_reg <= ST_IDLE;
            count_reg <= 16'd0;
            hold_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state logic: one FIFO pop per word, then two halfword beats.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    count_next = req_len;
                    // A zero-length request completes without touching the FIFO.
                    state_next = (req_len == 16'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!ob_empty) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ob_valid is only honoured here; stray strobes elsewhere are dropped.
                if (ob_valid) begin
                    hold_next  = ob_data;
                    state_next = ST_EMIT_LO;
                end
            end
            ST_EMIT_LO: begin
                if (px_ready) begin
                    state_next = ST_EMIT_HI;
                end
            end
            ST_EMIT_HI: begin
                if (px_ready) begin
                    count_next = count_reg - 16'd1;
                    state_next = (count_reg == 16'd1) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state and counter; the pop strobe is
    // additionally qualified by ob_empty so the FIFO is never underflowed.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        ob_re     = 1'b0;
        px_valid  = 1'b0;
        px_data   = 16'd0;
        px_last   = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Held low while reset is applied so the block looks unavailable.
                req_ready = ~reset_d;
                busy      = 1'b0;
            end
            ST_FETCH: begin
                ob_re = ~ob_empty;
            end
            ST_EMIT_LO: begin
                px_valid = 1'b1;
                px_data  = hold_reg[15:0];
            end
            ST_EMIT_HI: begin
                px_valid = 1'b1;
                px_data  = hold_reg[31:16];
                px_last  = (count_reg == 16'd1);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_blob_unpacker.sv
// Directed testbench for blob_unpacker with a small FIFO model and a
// negedge monitor that logs halfword beats, pops and done pulses.
module tb_blob_unpacker;

    logic        clk;
    logic        reset_d;
    logic        req_valid;
    logic [15:0] req_len;
    logic        req_ready;
    logic        ob_empty;
    logic        ob_re;
    logic [31:0] ob_data;
    logic        ob_valid;
    logic        px_valid;
    logic [15:0] px_data;
    logic        px_last;
    logic        px_ready;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    blob_unpacker dut (
        .clk       (clk),
        .reset_d   (reset_d),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .ob_empty  (ob_empty),
        .ob_re     (ob_re),
        .ob_data   (ob_data),
        .ob_valid  (ob_valid),
        .px_valid  (px_valid),
        .px_data   (px_data),
        .px_last   (px_last),
        .px_ready  (px_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pushes from the stimulus, pops from ob_re, data one cycle later.
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_flush;

    assign ob_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        ob_valid <= 1'b0;
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (ob_re) begin
            ob_data  <= fifo_mem[rd_ptr % 64];
            ob_valid <= 1'b1;
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Monitor on the falling edge, where inputs and outputs are settled.
    int          cyc = 0;
    logic [15:0] beat_data [$];
    bit          beat_last [$];
    int          beat_cyc  [$];
    int          re_cyc    [$];
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          pxv_cnt   = 0;
    int          stab_err  = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'd0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (px_valid && px_ready) begin
            beat_data.push_back(px_data);
            beat_last.push_back(px_last);
            beat_cyc.push_back(cyc);
        end
        if (ob_re) re_cyc.push_back(cyc);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (px_valid) pxv_cnt = pxv_cnt + 1;
        if (prev_stall && px_valid && (px_data !== prev_data)) stab_err = stab_err + 1;
        prev_stall = px_valid && !px_ready;
        prev_data  = px_data;
    end

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_req(input logic [15:0] len);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_len   = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (toggle) px_ready = ~px_ready;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({px_valid, ob_re, done, busy, px_last, req_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000", {px_valid, ob_re, done, busy, px_last, req_ready});
        end
        checks++;
        if (px_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_px_data: got %h expected 0000", px_data);
        end
        reset_d = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got req_ready=%b busy=%b expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int s, r0, d0;
        bit ok;
        logic [15:0] exp_d [4];
        bit          exp_l [4];
        exp_d = '{16'h4000, 16'h3C00, 16'h4400, 16'h4200};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        s = beat_data.size(); r0 = re_cyc.size(); d0 = done_cnt;
        push_word(32'h3C00_4000);
        push_word(32'h4200_4400);
        px_ready = 1'b1;
        do_req(16'd2);
        wait_done(60, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout: got no done expected done within 60 cycles"); end
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done_status: got req_ready=%b busy=%b expected 0 1", req_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_done_pulse: got done=%b req_ready=%b expected 0 1", done, req_ready);
        end
        checks++;
        if (beat_data.size() - s != 4) begin
            failures++;
            $display("FAIL basic_beats: got %0d expected 4", beat_data.size() - s);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_data[s+i] !== exp_d[i] || beat_last[s+i] !== exp_l[i]) begin
                    failures++;
                    $display("FAIL basic_beat%0d: got %h last=%b expected %h last=%b", i, beat_data[s+i], beat_last[s+i], exp_d[i], exp_l[i]);
                end
            end
            checks++;
            if (done_cyc != beat_cyc[s+3] + 1) begin
                failures++;
                $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, beat_cyc[s+3] + 1);
            end
            checks++;
            if (beat_cyc[s+2] - beat_cyc[s] != 4) begin
                failures++;
                $display("FAIL basic_word_rate: got %0d cycles expected 4", beat_cyc[s+2] - beat_cyc[s]);
            end
        end
        checks++;
        if (re_cyc.size() - r0 != 2) begin
            failures++;
            $display("FAIL basic_ob_re_count: got %0d expected 2", re_cyc.size() - r0);
        end else begin
            checks++;
            if (beat_data.size() - s >= 1 && beat_cyc[s] - re_cyc[r0] != 2) begin
                failures++;
                $display("FAIL basic_latency: got %0d expected 2", beat_cyc[s] - re_cyc[r0]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_zero_len();
        int r0, d0, v0;
        r0 = re_cyc.size(); d0 = done_cnt; v0 = pxv_cnt;
        do_req(16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_next: got done=%b busy=%b expected 1 1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_back_idle: got done=%b req_ready=%b expected 0 1", done, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (re_cyc.size() - r0 != 0 || pxv_cnt - v0 != 0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_activity: got ob_re=%0d px_valid=%0d done=%0d expected 0 0 1", re_cyc.size() - r0, pxv_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_empty_stall();
        int s, r0, bad;
        bit ok;
        s = beat_data.size(); r0 = re_cyc.size(); bad = 0;
        px_ready = 1'b1;
        do_req(16'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ob_re !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || re_cyc.size() - r0 != 0) begin
            failures++;
            $display("FAIL stall_no_pop: got %0d bad cycles %0d pops expected 0 0", bad, re_cyc.size() - r0);
        end
        push_word(32'hABCD_1234);
        wait_done(40, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_timeout: got no done expected done within 40 cycles"); end
        @(posedge clk); #1;
        checks++;
        if (re_cyc.size() - r0 != 1) begin
            failures++;
            $display("FAIL stall_pop_count: got %0d expected 1", re_cyc.size() - r0);
        end
        checks++;
        if (beat_data.size() - s != 2) begin
            failures++;
            $display("FAIL stall_beats: got %0d expected 2", beat_data.size() - s);
        end else begin
            checks++;
            if (beat_data[s] !== 16'h1234 || beat_data[s+1] !== 16'hABCD || beat_last[s] !== 1'b0 || beat_last[s+1] !== 1'b1) begin
                failures++;
                $display("FAIL stall_data: got %h/%b %h/%b expected 1234/0 abcd/1", beat_data[s], beat_last[s], beat_data[s+1], beat_last[s+1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s, e0;
        bit ok;
        logic [15:0] exp_d [6];
        exp_d = '{16'h5555, 16'hAAAA, 16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD};
        s = beat_data.size(); e0 = stab_err;
        push_word(32'hAAAA_5555);
        push_word(32'h1234_5678);
        push_word(32'hDEAD_BEEF);
        px_ready = 1'b0;
        do_req(16'd3);
        wait_done(100, 1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_timeout: got no done expected done within 100 cycles"); end
        @(posedge clk); #1;
        px_ready = 1'b1;
        checks++;
        if (stab_err - e0 != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d changes expected 0", stab_err - e0);
        end
        checks++;
        if (beat_data.size() - s != 6) begin
            failures++;
            $display("FAIL bp_beats: got %0d expected 6", beat_data.size() - s);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beat_data[s+i] !== exp_d[i] || beat_last[s+i] !== (i == 5)) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got %h last=%b expected %h last=%b", i, beat_data[s+i], beat_last[s+i], exp_d[i], (i == 5));
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int s, r0, d0, bad;
        bit ok;
        s = beat_data.size(); r0 = re_cyc.size(); d0 = done_cnt; bad = 0;
        push_word(32'h0102_0304);
        push_word(32'h0506_0708);
        px_ready = 1'b1;
        do_req(16'd2);
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_len   = 16'd5;
            if (req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_req_ready: got %0d high samples expected 0", bad);
        end
        wait_done(40, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL busy_timeout: got no done expected done within 40 cycles"); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || re_cyc.size() - r0 != 2 || beat_data.size() - s != 4 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL busy_ignored: got busy=%b pops=%0d beats=%0d dones=%0d expected 0 2 4 1", busy, re_cyc.size() - r0, beat_data.size() - s, done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort();
        int s, d0;
        bit found, ok;
        s = beat_data.size(); d0 = done_cnt; found = 1'b0;
        push_word(32'h1111_0001);
        push_word(32'h2222_0002);
        push_word(32'h3333_0003);
        push_word(32'h4444_0004);
        px_ready = 1'b1;
        do_req(16'd4);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (px_valid && px_data === 16'h2222) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL abort_reach_hi: got not found expected EMIT_HI of word 2"); end
        reset_d = 1'b1;
        #1;
        checks++;
        if ({px_valid, ob_re, done, busy, px_last} !== 5'b0 || px_data !== 16'h0000) begin
            failures++;
            $display("FAIL abort_outputs: got %b data=%h expected 00000 data=0000", {px_valid, ob_re, done, busy, px_last}, px_data);
        end
        @(posedge clk); #1;
        reset_d    = 1'b0;
        fifo_flush = 1'b1;
        @(posedge clk); #1;
        fifo_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 0 || busy !== 1'b0 || req_ready !== 1'b1 || beat_data.size() - s != 3) begin
            failures++;
            $display("FAIL abort_idle: got dones=%0d busy=%b ready=%b beats=%0d expected 0 0 1 3", done_cnt - d0, busy, req_ready, beat_data.size() - s);
        end
        s = beat_data.size();
        push_word(32'h5555_6666);
        do_req(16'd1);
        wait_done(40, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_restart_timeout: got no done expected done within 40 cycles"); end
        @(posedge clk); #1;
        checks++;
        if (beat_data.size() - s != 2) begin
            failures++;
            $display("FAIL abort_restart_beats: got %0d expected 2", beat_data.size() - s);
        end else begin
            checks++;
            if (beat_data[s] !== 16'h6666 || beat_data[s+1] !== 16'h5555 || beat_last[s+1] !== 1'b1) begin
                failures++;
                $display("FAIL abort_restart_data: got %h %h last=%b expected 6666 5555 last=1", beat_data[s], beat_data[s+1], beat_last[s+1]);
            end
        end
    endtask

    task automatic test_large_len();
        int s, r0, d0, lasts;
        s = beat_data.size(); r0 = re_cyc.size(); d0 = done_cnt; lasts = 0;
        push_word(32'h0A0A_0B0B);
        push_word(32'h0C0C_0D0D);
        push_word(32'h0E0E_0F0F);
        px_ready = 1'b1;
        do_req(16'hFFFF);
        repeat (30) @(posedge clk);
        #1;
        for (int i = s; i < beat_data.size(); i++) if (beat_last[i]) lasts++;
        checks++;
        if (beat_data.size() - s != 6 || lasts != 0 || busy !== 1'b1 || re_cyc.size() - r0 != 3) begin
            failures++;
            $display("FAIL large_len: got beats=%0d lasts=%0d busy=%b pops=%0d expected 6 0 1 3", beat_data.size() - s, lasts, busy, re_cyc.size() - r0);
        end
        reset_d = 1'b1;
        @(posedge clk); #1;
        reset_d = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done_cnt - d0 != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL large_abort: got dones=%0d busy=%b expected 0 0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_d    = 1'b1;
        req_valid  = 1'b0;
        req_len    = 16'd0;
        px_ready   = 1'b0;
        fifo_flush = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_empty_stall();
        test_backpressure();
        test_busy_ignore();
        test_reset_abort();
        test_large_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
